// File: rtl/leaf_out_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// leaf_out_arbiter_pkg
// Shared leaf packet definitions: default field widths, field offset helpers
// and a packet-format helper for the default geometry. The leaf interface
// blocks import this package so every block agrees on the packet layout:
//   MSB-first {valid, dest_leaf, dest_port, seq, payload}
// -----------------------------------------------------------------------------
package leaf_out_arbiter_pkg;

    localparam int unsigned DEF_LEAF_BITS    = 5;
    localparam int unsigned DEF_PORT_BITS    = 4;
    localparam int unsigned DEF_ADDR_BITS    = 7;
    localparam int unsigned DEF_PAYLOAD_BITS = 32;

    // Total packet width including the valid bit.
    function automatic int unsigned packet_bits(input int unsigned leaf_bits,
                                                input int unsigned port_bits,
                                                input int unsigned addr_bits,
                                                input int unsigned payload_bits);
        return 1 + leaf_bits + port_bits + addr_bits + payload_bits;
    endfunction

    // Field LSB positions within a packet.
    function automatic int unsigned seq_lsb(input int unsigned payload_bits);
        return payload_bits;
    endfunction

    function automatic int unsigned port_lsb(input int unsigned addr_bits,
                                             input int unsigned payload_bits);
        return payload_bits + addr_bits;
    endfunction

    function automatic int unsigned leaf_lsb(input int unsigned port_bits,
                                             input int unsigned addr_bits,
                                             input int unsigned payload_bits);
        return payload_bits + addr_bits + port_bits;
    endfunction

    localparam int unsigned DEF_PACKET_BITS =
        packet_bits(DEF_LEAF_BITS, DEF_PORT_BITS, DEF_ADDR_BITS, DEF_PAYLOAD_BITS);

    typedef struct packed {
        logic                        valid;
        logic [DEF_LEAF_BITS-1:0]    dest_leaf;
        logic [DEF_PORT_BITS-1:0]    dest_port;
        logic [DEF_ADDR_BITS-1:0]    seq;
        logic [DEF_PAYLOAD_BITS-1:0] payload;
    } leaf_packet_t;

    // Build a valid packet at the default geometry.
    function automatic leaf_packet_t format_packet(input logic [DEF_LEAF_BITS-1:0]    dest_leaf,
                                                   input logic [DEF_PORT_BITS-1:0]    dest_port,
                                                   input logic [DEF_ADDR_BITS-1:0]    seq,
                                                   input logic [DEF_PAYLOAD_BITS-1:0] payload);
        leaf_packet_t pkt;
        pkt.valid     = 1'b1;
        pkt.dest_leaf = dest_leaf;
        pkt.dest_port = dest_port;
        pkt.seq       = seq;
        pkt.payload   = payload;
        return pkt;
    endfunction

endpackage

// File: rtl/leaf_out_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a one-hot grant. The search starts at the port after
// the last accepted grant and wraps at WIDTH. The pointer only moves when the
// grant is accepted.
// Ports:
//   clk_i     - clock
//   reset_i   - synchronous active-high reset (pointer -> WIDTH-1)
//   req_i     - per-requester request
//   accept_i  - the current grant was taken; advance the pointer
//   gnt_o     - one-hot grant (all zero when nothing requests)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] req_i,
    input  logic             accept_i,
    output logic [WIDTH-1:0] gnt_o
);

    localparam int unsigned PTR_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [PTR_BITS-1:0] last_q, last_d;
    logic [PTR_BITS-1:0] idx_p;
    logic                found;
    int unsigned         idx;

    always_comb begin
        gnt_o  = '0;
        last_d = last_q;
        found  = 1'b0;
        idx    = 0;
        idx_p  = '0;
        for (int unsigned off = 1; off <= WIDTH; off++) begin
            idx = {{(32-PTR_BITS){1'b0}}, last_q} + off;
            if (idx >= WIDTH) begin
                idx = idx - WIDTH;
            end
            idx_p = PTR_BITS'(idx);
            if (!found && req_i[idx_p]) begin
                found        = 1'b1;
                gnt_o[idx_p] = 1'b1;
                last_d       = idx_p;
            end
        end
        if (!accept_i) begin
            last_d = last_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_q <= PTR_BITS'(WIDTH - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/leaf_out_arbiter.sv
// -----------------------------------------------------------------------------
// leaf_out_arbiter
// Merges NUM_OUT_PORTS user streams into one packet stream towards the BFT.
// Each port has a configurable destination, a per-port sequence counter and a
// credit counter replenished by freespace updates from the downstream leaf.
// Ports:
//   clk, reset                - single clock, synchronous active-high reset
//   din_leaf_user2interface   - user payloads, port i at slice i
//   vld_user2interface        - per-port valid
//   ack_interface2user        - per-port accept (combinational, one-hot)
//   cfg_wr_en/cfg_port/cfg_dest - destination table write {leaf, port}
//   credit_upd_vld/credit_upd_port - freespace return (+FREESPACE_UPDATE_SIZE)
//   dout_leaf_interface2bft   - registered packet, MSB = valid, idle = 0
//   bft_rdy                   - BFT takes the current packet this cycle
// -----------------------------------------------------------------------------
module leaf_out_arbiter
    import leaf_out_arbiter_pkg::*;
#(
    parameter int unsigned NUM_OUT_PORTS         = 3,
    parameter int unsigned PAYLOAD_BITS          = 32,
    parameter int unsigned NUM_LEAF_BITS         = 5,
    parameter int unsigned NUM_PORT_BITS         = 4,
    parameter int unsigned NUM_ADDR_BITS         = 7,
    parameter int unsigned FREESPACE_UPDATE_SIZE = 64,
    parameter int unsigned CREDIT_MAX            = 128,
    localparam int unsigned PACKET_BITS =
        packet_bits(NUM_LEAF_BITS, NUM_PORT_BITS, NUM_ADDR_BITS, PAYLOAD_BITS)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
    input  logic                                    cfg_wr_en,
    input  logic [NUM_PORT_BITS-1:0]                cfg_port,
    input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0]  cfg_dest,
    input  logic                                    credit_upd_vld,
    input  logic [NUM_PORT_BITS-1:0]                credit_upd_port,
    output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft,
    input  logic                                    bft_rdy
);

    localparam int unsigned DEST_BITS   = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int unsigned CREDIT_BITS = $clog2(CREDIT_MAX + 1);
    // Wide enough to hold a full counter plus one update before saturating.
    localparam int unsigned SUM_BITS    = $clog2(CREDIT_MAX + FREESPACE_UPDATE_SIZE + 1);
    localparam logic [SUM_BITS-1:0] CREDIT_CAP = SUM_BITS'(CREDIT_MAX);
    localparam logic [SUM_BITS-1:0] UPD_INC    = SUM_BITS'(FREESPACE_UPDATE_SIZE);
    localparam int unsigned VALID_POS   = PACKET_BITS - 1;

    logic [NUM_OUT_PORTS-1:0][DEST_BITS-1:0]     dest_q, dest_d;
    logic [NUM_OUT_PORTS-1:0]                    cfg_vld_q, cfg_vld_d;
    logic [NUM_OUT_PORTS-1:0][NUM_ADDR_BITS-1:0] seq_q, seq_d;
    logic [NUM_OUT_PORTS-1:0][CREDIT_BITS-1:0]   credit_q, credit_d;
    logic [PACKET_BITS-1:0]                      out_q, out_d;

    logic                      out_free;
    logic [NUM_OUT_PORTS-1:0]  eligible;
    logic [NUM_OUT_PORTS-1:0]  req;
    logic [NUM_OUT_PORTS-1:0]  gnt;
    logic [NUM_OUT_PORTS-1:0]  xfer;
    logic [DEST_BITS-1:0]      sel_dest;
    logic [NUM_ADDR_BITS-1:0]  sel_seq;
    logic [PAYLOAD_BITS-1:0]   sel_payload;
    logic [SUM_BITS-1:0]       cred_sum;

    // The output slot frees up when empty or when its packet is taken now.
    assign out_free = !out_q[VALID_POS] || bft_rdy;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            eligible[i] = vld_user2interface[i] && cfg_vld_q[i] && (credit_q[i] != '0);
        end
        // No grants while in reset so nothing is acked that cycle.
        req = (out_free && !reset) ? eligible : '0;
    end

    rr_arbiter #(
        .WIDTH (NUM_OUT_PORTS)
    ) u_rr_arbiter (
        .clk_i    (clk),
        .reset_i  (reset),
        .req_i    (req),
        .accept_i (|gnt),
        .gnt_o    (gnt)
    );

    assign ack_interface2user = gnt;
    // A grant is only given to a valid port, so every grant is a transfer.
    assign xfer = gnt & vld_user2interface;

    // AND-OR mux of the granted port's fields (grant is one-hot).
    always_comb begin
        sel_dest    = '0;
        sel_seq     = '0;
        sel_payload = '0;
        for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            if (gnt[i]) begin
                sel_dest    |= dest_q[i];
                sel_seq     |= seq_q[i];
                sel_payload |= din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    always_comb begin
        out_d = out_q;
        if (out_free) begin
            if (|xfer) begin
                out_d = {1'b1, sel_dest, sel_seq, sel_payload};
            end else begin
                out_d = '0;
            end
        end
    end

    always_comb begin
        dest_d    = dest_q;
        cfg_vld_d = cfg_vld_q;
        seq_d     = seq_q;
        credit_d  = credit_q;
        cred_sum  = '0;
        for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            // Out-of-range ports never match any i, so they are ignored.
            if (cfg_wr_en && (cfg_port == NUM_PORT_BITS'(i))) begin
                dest_d[i]    = cfg_dest;
                cfg_vld_d[i] = 1'b1;
            end

            seq_d[i] = seq_q[i] + NUM_ADDR_BITS'(xfer[i]);

            cred_sum = SUM_BITS'(credit_q[i]);
            if (credit_upd_vld && (credit_upd_port == NUM_PORT_BITS'(i))) begin
                cred_sum = cred_sum + UPD_INC;
            end
            if (xfer[i]) begin
                cred_sum = cred_sum - SUM_BITS'(1);
            end
            if (cred_sum > CREDIT_CAP) begin
                cred_sum = CREDIT_CAP;
            end
            credit_d[i] = cred_sum[CREDIT_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q     <= '0;
            dest_q    <= '0;
            cfg_vld_q <= '0;
            seq_q     <= '0;
            for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
                credit_q[i] <= CREDIT_BITS'(CREDIT_MAX);
            end
        end else begin
            out_q     <= out_d;
            dest_q    <= dest_d;
            cfg_vld_q <= cfg_vld_d;
            seq_q     <= seq_d;
            credit_q  <= credit_d;
        end
    end

    assign dout_leaf_interface2bft = out_q;

endmodule

// File: doc/leaf_out_arbiter.md
LEAF_OUT_ARBITER -- requirements
Module: leaf_out_arbiter

Interface
REQ-001 SHALL take parameter NUM_OUT_PORTS, default 3: number of user output streams, 1..2^NUM_PORT_BITS-1.
REQ-002 SHALL take parameter PAYLOAD_BITS, default 32: user data width.
REQ-003 SHALL take parameters NUM_LEAF_BITS 5, NUM_PORT_BITS 4 and NUM_ADDR_BITS 7: the destination leaf, port and sequence field widths.
REQ-004 SHALL derive PACKET_BITS = 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS (49 at defaults).
REQ-005 SHALL take parameter FREESPACE_UPDATE_SIZE, default 64: credits returned per update; CREDIT_MAX default 128 is the credit counter ceiling and reset value.
REQ-006 SHALL have ports clk in 1 (the single clock) and reset in 1 (synchronous, active-high).
REQ-007 SHALL have port din_leaf_user2interface in NUM_OUT_PORTS*PAYLOAD_BITS: user payloads, with port i at slice i.
REQ-008 SHALL have ports vld_user2interface in NUM_OUT_PORTS (per-port valid) and ack_interface2user out NUM_OUT_PORTS (per-port accept).
REQ-009 SHALL have ports cfg_wr_en in 1, cfg_port in NUM_PORT_BITS and cfg_dest in NUM_LEAF_BITS+NUM_PORT_BITS: the destination table write.
REQ-010 SHALL have ports credit_upd_vld in 1 and credit_upd_port in NUM_PORT_BITS: the freespace return from the downstream leaf.
REQ-011 SHALL have ports dout_leaf_interface2bft out PACKET_BITS (packet to BFT, MSB = valid) and bft_rdy in 1 (BFT accepts the current packet).

Function
REQ-012 SHALL format packets as MSB-first {1'b1, dest_leaf, dest_port, seq, payload}; an idle output is all-zero.
REQ-013 SHALL mark port i eligible when vld[i]=1, its destination entry is configured, and credit[i]>0.
REQ-014 SHALL treat the output register as free when its valid bit is 0, or when it is 1 and bft_rdy=1 in the same cycle.
REQ-015 SHALL, when the output register is free, grant exactly one eligible port round-robin, searching from last_grant+1 with wrap-around at NUM_OUT_PORTS.
REQ-016 SHALL drive ack_interface2user[g] combinationally high only for the granted port g; every other bit is 0.
REQ-017 SHALL count a transfer when vld&ack; the packet appears on dout the next cycle (1-cycle latency).
REQ-018 SHALL hold the output packet unchanged while valid=1 and bft_rdy=0; no ack is issued in those cycles.
REQ-019 SHALL clear the output to all-zero when free and no port is eligible.
REQ-020 SHALL set seq from the port's sequence counter, which increments per transfer modulo 2^NUM_ADDR_BITS (127 -> 0).
REQ-021 SHALL decrement credit[i] on a transfer and add FREESPACE_UPDATE_SIZE on a credit update; simultaneous events apply the net (+63).
REQ-022 SHALL saturate credits at CREDIT_MAX and ignore updates for ports >= NUM_OUT_PORTS.
REQ-023 SHALL never ack a port whose credit is 0; the port stalls until an update arrives.
REQ-024 SHALL, on cfg_wr_en, write the entry and set its configured bit next cycle, without altering credit or seq; writes to ports >= NUM_OUT_PORTS are ignored.
REQ-025 SHALL update last_grant only on a transfer.

Reset
REQ-026 SHALL, on reset=1 at a clk edge, clear the output register to all-zero and drive ack to 0 during reset.
REQ-027 SHALL, on reset, clear all configured bits, zero the seq counters, set credits to CREDIT_MAX and set last_grant to NUM_OUT_PORTS-1.
REQ-028 SHALL drop any in-flight packet on reset mid-transfer, with no ack issued that cycle.

Structure
REQ-029 SHALL place the packet field widths, field offsets and the packet-format helper in the shared leaf package, reused by leaf_interface.
REQ-030 SHALL use one sub-module, rr_arbiter (parametrised request width, one-hot grant, pointer advance on accept), with credit, seq and table logic inline.

Verification
REQ-031 SHALL verify default params: configure port 0 -> leaf 3/port 2, drive vld[0] with 0xDEADBEEF, bft_rdy=1 -> next cycle dout = {1,5'd3,4'd2,7'd0,32'hDEADBEEF}, ack[0] high 1 cycle.
REQ-032 SHALL verify that with all 3 ports configured and valid, bft_rdy=1 for 6 cycles, grants run 0,1,2,0,1,2 and each port's seq is 0 then 1.
REQ-033 SHALL verify that with bft_rdy=0 for 4 cycles and port 1 valid, dout stays stable, ack is 0 after the first transfer, and the transfer resumes the cycle bft_rdy=1.
REQ-034 SHALL verify that sending 128 words on port 0 drops credit to 0 and port 0 stalls; a credit update then gives a transfer next cycle; a simultaneous send+update gives credit 63.
REQ-035 SHALL verify that 130 transfers on one port produce a seq wrap 127 -> 0 -> 1 and an unconfigured port with vld=1 is never acked.
REQ-036 SHALL verify that asserting reset while the output is valid gives dout=0 next cycle, credits 128 and configured bits cleared.
